// File: rtl/gb_video_pkg.sv
// Shared constants and types for the Game Boy scaler video path.
package gb_video_pkg;

    localparam int unsigned GB_W  = 160;
    localparam int unsigned GB_H  = 144;
    localparam int unsigned FB_AW = 15;

    // Indexed by the 2-bit shade; entry 0 is the lightest green.
    localparam logic [3:0][23:0] PALETTE = {24'h0F380F, 24'h306230, 24'h8BAC0F, 24'h9BBC0F};

    typedef enum logic [1:0] {
        PX_BORDER,
        PX_BG,
        PX_WIN
    } px_class_e;

endpackage

// File: rtl/gb_addr_gen.sv
// Incremental framebuffer address generator: each source pixel is repeated SCALE times
// horizontally and each source row SCALE times vertically, without multiply or divide.
module gb_addr_gen
    import gb_video_pkg::*;
#(
    parameter int unsigned LINE_PX = GB_W,
    parameter int unsigned SCALE   = 3,
    parameter int unsigned AW      = FB_AW
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          vs_rise_i,
    input  logic          win_i,
    output logic [AW-1:0] fb_addr_o,
    output logic          fb_rd_o
);

    localparam int unsigned SW = (SCALE > 1) ? $clog2(SCALE) : 1;
    localparam int unsigned GW = $clog2(LINE_PX + 1);
    localparam logic [SW-1:0] S_LAST = SW'(SCALE - 1);

    logic [SW-1:0] sx_q, sx_d;
    logic [SW-1:0] sy_q, sy_d;
    logic [GW-1:0] gx_q, gx_d;
    logic [AW-1:0] row_base_q, row_base_d;
    logic          win_q, win_d;
    logic          line_end;

    assign line_end = win_q & ~win_i;

    always_comb begin
        sx_d       = sx_q;
        gx_d       = gx_q;
        sy_d       = sy_q;
        row_base_d = row_base_q;
        win_d      = win_i;

        // Outside the window the per-line position is held at zero, ready for the next start.
        if (!win_i || vs_rise_i) begin
            sx_d = '0;
            gx_d = '0;
        end else if (sx_q == S_LAST) begin
            sx_d = '0;
            gx_d = gx_q + 1'b1;
        end else begin
            sx_d = sx_q + 1'b1;
        end

        if (vs_rise_i) begin
            sy_d       = '0;
            row_base_d = '0;
        end else if (line_end) begin
            if (sy_q == S_LAST) begin
                sy_d       = '0;
                row_base_d = row_base_q + AW'(LINE_PX);
            end else begin
                sy_d = sy_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sx_q       <= '0;
            gx_q       <= '0;
            sy_q       <= '0;
            row_base_q <= '0;
            win_q      <= 1'b0;
        end else begin
            sx_q       <= sx_d;
            gx_q       <= gx_d;
            sy_q       <= sy_d;
            row_base_q <= row_base_d;
            win_q      <= win_d;
        end
    end

    assign fb_addr_o = row_base_q + AW'(gx_q);
    assign fb_rd_o   = win_i;

endmodule

// File: rtl/gb_scaler.sv
// Scales the 160x144 Game Boy framebuffer 3x into a centred window of the active frame,
// tracking position from the sync generator and delaying timing to match the RGB pipeline.
module gb_scaler #(
    parameter int unsigned XRES   = 640,
    parameter int unsigned YRES   = 480,
    parameter int unsigned GB_W   = gb_video_pkg::GB_W,
    parameter int unsigned GB_H   = gb_video_pkg::GB_H,
    parameter int unsigned SCALE  = 3,
    parameter int unsigned X_OFF  = (XRES - GB_W * SCALE) / 2,
    parameter int unsigned Y_OFF  = (YRES - GB_H * SCALE) / 2,
    parameter logic [23:0] BG_RGB = 24'h202020
) (
    input  logic                            fbclk,
    input  logic                            rst,
    input  logic                            hs_in,
    input  logic                            vs_in,
    input  logic                            border_in,
    output logic [gb_video_pkg::FB_AW-1:0]  fb_addr,
    output logic                            fb_rd,
    input  logic [1:0]                      fb_data,
    output logic                            hs_out,
    output logic                            vs_out,
    output logic                            border_out,
    output logic [23:0]                     rgb
);

    import gb_video_pkg::*;

    localparam int unsigned XW = $clog2(XRES + 1);
    localparam int unsigned YW = $clog2(YRES + 1);
    localparam logic [XW-1:0] X_LO  = XW'(X_OFF);
    localparam logic [XW-1:0] X_HI  = XW'(X_OFF + GB_W * SCALE);
    localparam logic [YW-1:0] Y_LO  = YW'(Y_OFF);
    localparam logic [YW-1:0] Y_HI  = YW'(Y_OFF + GB_H * SCALE);
    localparam logic [YW-1:0] Y_MAX = YW'(YRES);

    logic [XW-1:0] ax_q, ax_d;
    logic [YW-1:0] ay_q, ay_d;
    logic          vs_prev_q, vs_prev_d;
    logic          border_prev_q, border_prev_d;
    logic          synced_q, synced_d;
    logic [1:0]    hs_dly_q, hs_dly_d;
    logic [1:0]    vs_dly_q, vs_dly_d;
    logic [1:0]    bd_dly_q, bd_dly_d;
    px_class_e     cls_q, cls_d;
    logic [23:0]   rgb_q, rgb_d;

    logic vs_rise;
    logic border_rise;
    logic win;

    assign vs_rise     = vs_in & ~vs_prev_q;
    assign border_rise = border_in & ~border_prev_q;
    assign win         = !border_in && synced_q
                         && (ax_q >= X_LO) && (ax_q < X_HI)
                         && (ay_q >= Y_LO) && (ay_q < Y_HI);

    always_comb begin
        vs_prev_d     = vs_in;
        border_prev_d = border_in;
        synced_d      = synced_q | vs_rise;
        ax_d          = border_in ? '0 : ax_q + 1'b1;

        // A vsync edge always wins over a coincident end-of-line.
        ay_d = ay_q;
        if (vs_rise) begin
            ay_d = '0;
        end else if (border_rise && (ay_q < Y_MAX)) begin
            ay_d = ay_q + 1'b1;
        end

        hs_dly_d = {hs_dly_q[0], hs_in};
        vs_dly_d = {vs_dly_q[0], vs_in};
        bd_dly_d = {bd_dly_q[0], border_in};

        if (border_in || !synced_q) begin
            cls_d = PX_BORDER;
        end else if (win) begin
            cls_d = PX_WIN;
        end else begin
            cls_d = PX_BG;
        end

        // fb_data lines up with cls_q: both belong to the pixel issued one cycle earlier.
        unique case (cls_q)
            PX_WIN:  rgb_d = PALETTE[fb_data];
            PX_BG:   rgb_d = BG_RGB;
            default: rgb_d = '0;
        endcase
    end

    always_ff @(posedge fbclk) begin
        if (rst) begin
            ax_q          <= '0;
            ay_q          <= '0;
            vs_prev_q     <= 1'b0;
            border_prev_q <= 1'b0;
            synced_q      <= 1'b0;
            hs_dly_q      <= '0;
            vs_dly_q      <= '0;
            bd_dly_q      <= '0;
            cls_q         <= PX_BORDER;
            rgb_q         <= '0;
        end else begin
            ax_q          <= ax_d;
            ay_q          <= ay_d;
            vs_prev_q     <= vs_prev_d;
            border_prev_q <= border_prev_d;
            synced_q      <= synced_d;
            hs_dly_q      <= hs_dly_d;
            vs_dly_q      <= vs_dly_d;
            bd_dly_q      <= bd_dly_d;
            cls_q         <= cls_d;
            rgb_q         <= rgb_d;
        end
    end

    gb_addr_gen #(
        .LINE_PX (GB_W),
        .SCALE   (SCALE),
        .AW      (FB_AW)
    ) u_addr_gen (
        .clk_i     (fbclk),
        .rst_i     (rst),
        .vs_rise_i (vs_rise),
        .win_i     (win),
        .fb_addr_o (fb_addr),
        .fb_rd_o   (fb_rd)
    );

    assign hs_out     = hs_dly_q[1];
    assign vs_out     = vs_dly_q[1];
    assign border_out = bd_dly_q[1];
    assign rgb        = rgb_q;

endmodule

// File: tb/tb_gb_scaler.sv
// Directed bench for gb_scaler: compressed frames with short lines, a spot-check vector table
// and a per-cycle reference for fb_rd/fb_addr/rgb and the delayed timing outputs.
module tb_gb_scaler;

    localparam logic [23:0] BG = 24'h202020;

    typedef struct {
        int          line;
        int          ax;
        logic        rd;
        logic [14:0] addr;
        logic        chk_rgb;
        logic [23:0] rgb;
    } vec_t;

    logic        fbclk = 1'b0;
    logic        rst = 1'b1;
    logic        hs_in = 1'b0;
    logic        vs_in = 1'b0;
    logic        border_in = 1'b1;
    logic [14:0] fb_addr;
    logic        fb_rd;
    logic [1:0]  fb_data = 2'd0;
    logic        hs_out;
    logic        vs_out;
    logic        border_out;
    logic [23:0] rgb;

    int n_cmp = 0;
    int n_bad = 0;
    int rd_cnt = 0;
    int cur_line = 0;
    int cur_ax = 0;
    int ti = 0;
    bit chk_on = 0;
    bit tbl_on = 0;

    // Reference state: expected rgb/timing two cycles back, and sync status.
    logic [23:0] px_p0 = '0, px_p1 = '0;
    logic [2:0]  tm_p0 = '0, tm_p1 = '0;
    logic        m_synced = 1'b0;
    logic        m_vs_prev = 1'b0;

    logic        s_rd;
    logic [14:0] s_addr;
    logic [23:0] s_rgb;

    vec_t tbl[$];

    gb_scaler dut (
        .fbclk      (fbclk),
        .rst        (rst),
        .hs_in      (hs_in),
        .vs_in      (vs_in),
        .border_in  (border_in),
        .fb_addr    (fb_addr),
        .fb_rd      (fb_rd),
        .fb_data    (fb_data),
        .hs_out     (hs_out),
        .vs_out     (vs_out),
        .border_out (border_out),
        .rgb        (rgb)
    );

    always #5 fbclk = ~fbclk;

    // Framebuffer model: shade = low two address bits, returned one cycle after the strobe.
    always @(posedge fbclk) begin
        if (fb_rd) fb_data <= fb_addr[1:0];
    end

    function automatic logic [23:0] pal(input logic [1:0] s);
        case (s)
            2'd0:    return 24'h9BBC0F;
            2'd1:    return 24'h8BAC0F;
            2'd2:    return 24'h306230;
            default: return 24'h0F380F;
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (line %0d ax %0d, t=%0t)",
                     name, act, exp, cur_line, cur_ax, $time);
        end
    endtask

    // One pixel clock: drive inputs, check at the falling edge, advance the reference.
    task automatic step(input logic r, input logic h, input logic v, input logic b,
                        input int line, input int ax);
        logic        exp_rd;
        int          ea;
        logic [23:0] exp_px;
        rst = r; hs_in = h; vs_in = v; border_in = b;
        cur_line = line; cur_ax = ax;
        exp_rd = !b && m_synced && ax >= 80 && ax < 560 && line >= 24 && line < 456;
        ea = ((line - 24) / 3) * 160 + (ax - 80) / 3;
        if (b || !m_synced) exp_px = 24'h0;
        else if (exp_rd)    exp_px = pal(ea[1:0]);
        else                exp_px = BG;
        @(negedge fbclk);
        s_rd = fb_rd; s_addr = fb_addr; s_rgb = rgb;
        if (chk_on) begin
            chk("fb_rd", fb_rd, exp_rd);
            if (exp_rd) chk("fb_addr", fb_addr, ea[14:0]);
            chk("rgb", rgb, px_p1);
            chk("timing_out", {hs_out, vs_out, border_out}, tm_p1);
        end
        if (fb_rd === 1'b1) rd_cnt++;
        if (r) begin
            px_p0 = '0; px_p1 = '0; tm_p0 = '0; tm_p1 = '0;
            m_synced = 1'b0; m_vs_prev = 1'b0;
        end else begin
            px_p1 = px_p0; px_p0 = exp_px;
            tm_p1 = tm_p0; tm_p0 = {h, v, b};
            if (v && !m_vs_prev) m_synced = 1'b1;
            m_vs_prev = v;
        end
        @(posedge fbclk);
        #1;
    endtask

    // Active line of len pixels then 4 blanking cycles; optional vsync inside or at the end.
    task automatic run_line(input int line, input int len, input int vs_at, input bit vs_end);
        int   ln;
        logic v;
        ln = line;
        for (int ax = 0; ax < len; ax++) begin
            v = (vs_at >= 0) && (ax == vs_at || ax == vs_at + 1);
            step(1'b0, 1'b0, v, 1'b0, ln, ax);
            if (vs_at >= 0 && ax == vs_at) ln = 0;
            if (tbl_on && ti < tbl.size() && tbl[ti].line == line && tbl[ti].ax == ax) begin
                chk("tbl_rd", s_rd, tbl[ti].rd);
                if (tbl[ti].rd) chk("tbl_addr", s_addr, tbl[ti].addr);
                if (tbl[ti].chk_rgb) chk("tbl_rgb", s_rgb, tbl[ti].rgb);
                ti++;
            end
        end
        for (int k = 0; k < 4; k++) step(1'b0, k == 1, vs_end && k < 2, 1'b1, 0, 0);
    endtask

    task automatic vblank(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, k < 2, 1'b1, 0, 0);
    endtask

    function automatic int len1(input int l);
        if (l == 24 || l == 455 || l == 456) return 640;
        if (l < 24 || l > 456) return 16;
        return 84;
    endfunction

    function automatic int len2(input int l);
        return (l < 24) ? 16 : 84;
    endfunction

    initial begin
        //                line ax   rd    addr      rgb?  rgb
        tbl.push_back('{10,  12,  1'b0, 15'd0,     1'b1, BG});
        tbl.push_back('{23,  12,  1'b0, 15'd0,     1'b1, BG});
        tbl.push_back('{24,  1,   1'b0, 15'd0,     1'b1, 24'h000000});
        tbl.push_back('{24,  79,  1'b0, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{24,  80,  1'b1, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{24,  81,  1'b1, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{24,  82,  1'b1, 15'd0,     1'b1, 24'h9BBC0F});
        tbl.push_back('{24,  83,  1'b1, 15'd1,     1'b0, 24'h0});
        tbl.push_back('{24,  85,  1'b1, 15'd1,     1'b1, 24'h8BAC0F});
        tbl.push_back('{24,  559, 1'b1, 15'd159,   1'b0, 24'h0});
        tbl.push_back('{24,  560, 1'b0, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{25,  80,  1'b1, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{26,  80,  1'b1, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{27,  80,  1'b1, 15'd160,   1'b0, 24'h0});
        tbl.push_back('{27,  82,  1'b1, 15'd160,   1'b1, 24'h9BBC0F});
        tbl.push_back('{27,  83,  1'b1, 15'd161,   1'b0, 24'h0});
        tbl.push_back('{100, 80,  1'b1, 15'd4000,  1'b0, 24'h0});
        tbl.push_back('{455, 80,  1'b1, 15'd22880, 1'b0, 24'h0});
        tbl.push_back('{455, 559, 1'b1, 15'd23039, 1'b0, 24'h0});
        tbl.push_back('{455, 560, 1'b0, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{455, 561, 1'b0, 15'd0,     1'b1, 24'h0F380F});
        tbl.push_back('{455, 563, 1'b0, 15'd0,     1'b1, BG});
        tbl.push_back('{456, 80,  1'b0, 15'd0,     1'b0, 24'h0});
        tbl.push_back('{456, 300, 1'b0, 15'd0,     1'b0, 24'h0});

        // Reset held 5 cycles, released in the middle of an active line.
        step(1'b1, 1'b0, 1'b0, 1'b1, 0, 0);
        chk_on = 1;
        for (int k = 0; k < 4; k++) step(1'b1, k[0], 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 50; k++) step(1'b0, 1'b0, 1'b0, 1'b0, 0, 0);
        for (int k = 0; k < 4; k++) step(1'b0, k == 1, 1'b0, 1'b1, 0, 0);
        // Enough lines to pass through the window rows while still unsynced.
        for (int l = 0; l < 30; l++) run_line(l, 84, -1, 1'b0);
        chk("presync_rd_cnt", rd_cnt, 0);

        // Frame 1: full walk with spot-check table.
        vblank(10);
        rd_cnt = 0;
        tbl_on = 1;
        for (int l = 0; l < 480; l++) run_line(l, len1(l), -1, 1'b0);
        tbl_on = 0;
        chk("frame_rd_cnt", rd_cnt, 2680);
        chk("tbl_visited", ti, tbl.size());

        // Frame 2: vsync mid-frame at line 200, then vsync coincident with end of line 30.
        vblank(10);
        for (int l = 0; l < 200; l++) run_line(l, len2(l), -1, 1'b0);
        rd_cnt = 0;
        run_line(200, 84, 40, 1'b0);
        for (int l = 1; l <= 30; l++) run_line(l, len2(l), -1, l == 30);
        for (int l = 0; l < 28; l++) run_line(l, len2(l), -1, 1'b0);
        chk("restart_rd_cnt", rd_cnt, 44);

        // Reset in the middle of a window line: black until the next vsync, then resume.
        for (int ax = 0; ax < 84; ax++) step(ax == 81, 1'b0, 1'b0, 1'b0, 28, ax);
        for (int k = 0; k < 4; k++) step(1'b0, k == 1, 1'b0, 1'b1, 0, 0);
        for (int l = 0; l < 5; l++) run_line(l, 84, -1, 1'b0);
        vblank(10);
        for (int l = 0; l < 27; l++) run_line(l, len2(l), -1, 1'b0);
        vblank(4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gb_scaler.md
Name: gb_scaler

Overview:
- Sits directly downstream of the sync generator.
- Consumes its hs/vs/border timing and fetches Game Boy pixels (160x144, 2-bit shades) from the framebuffer RAM.
- Scales them 3x into a centred 480x432 window of the 640x480 frame.
- Emits RGB with timing signals delayed to match, feeding the DVI encoder.

Parameters:
- XRES, 640, active pixels per line (must match sync generator)
- YRES, 480, active lines per frame
- GB_W, 160, framebuffer width in pixels
- GB_H, 144, framebuffer height in lines
- SCALE, 3, integer upscale factor, same for x and y
- X_OFF, 80, first active column of the window: (XRES-GB_W*SCALE)/2
- Y_OFF, 24, first active line of the window: (YRES-GB_H*SCALE)/2
- BG_RGB, 24'h202020, colour inside the active area but outside the window

Ports:
- fbclk  in  1  pixel clock; same clock as the sync generator
- rst  in  1  synchronous, active-high reset
- hs_in  in  1  hsync from sync generator
- vs_in  in  1  vsync from sync generator
- border_in  in  1  1 = blanking (outside XRES x YRES)
- fb_addr  out  15  framebuffer read address, gy*GB_W+gx
- fb_rd  out  1  read strobe, high when fb_addr is valid
- fb_data  in  2  RAM read data, valid exactly 1 cycle after fb_rd
- hs_out  out  1  hs_in delayed 2 cycles
- vs_out  out  1  vs_in delayed 2 cycles
- border_out  out  1  border_in delayed 2 cycles
- rgb  out  24  {R,G,B}, registered

Behaviour:
- Interface: single clock fbclk; reset rst is synchronous, active-high.
- Reset values: all outputs 0; all counters 0; delay lines 0; synced=0.
- Sync tracking:
  - synced is set on the first vs_in rising edge after reset.
  - While synced=0: fb_rd=0 and rgb=0.
  - Timing outputs are always delayed and passed through, whether or not synced is set.
- Position counters:
  - ax increments on each cycle with border_in=0 and clears on any cycle with border_in=1.
  - ay increments on each border_in 0->1 transition occurring while ay<YRES.
  - ay clears on a vs_in rising edge; a vs arriving mid-frame therefore restarts the frame immediately.
- Window: win = !border_in && synced && ax in [X_OFF, X_OFF+GB_W*SCALE) && ay in [Y_OFF, Y_OFF+GB_H*SCALE).
- Address generation is incremental; no multiplier or divider is used.
  - Horizontal sub-counter sx counts 0..SCALE-1; gx increments when sx wraps.
  - Vertical sub-counter sy counts 0..SCALE-1, advanced at end of each window line.
  - row_base += GB_W when sy wraps.
  - sx, gx and the per-line address clear at window start each line.
  - sy, row_base and the address clear on vs_in rising edge.
  - fb_addr = row_base + gx, combinational from registered state.
  - fb_rd = win.
  - Last pixel address = 23039; nothing is read beyond it.
- Pipeline:
  - Stage 0: fb_addr/fb_rd, and capture of the class (border / window / background).
  - Stage 1: RAM returns fb_data; class is carried along.
  - Stage 2: rgb is registered.
  - Total latency is 2 cycles from hs/vs/border_in to the matching hs/vs/border_out and rgb.
- Colour:
  - border → 0.
  - Window → palette[fb_data]: 0=9BBC0F, 1=8BAC0F, 2=306230, 3=0F380F.
  - Other active pixels → BG_RGB.
- Reset mid-frame: output returns to reset values on the next cycle. Output stays black until the next vs rising edge, then resumes correctly from line 0.
- Simultaneous vs rising edge and border transition: the vs clear wins; ay=0.

Decomposition:
- Package gb_video_pkg:
  - GB_W/GB_H constants
  - the 4-entry palette as a constant array
  - typedef of the pixel class enum {PX_BORDER, PX_BG, PX_WIN}
- One sub-module, gb_addr_gen, holding the sx/sy/gx/row_base counters and emitting fb_addr/fb_rd.
- The top module holds sync tracking, delay lines and the colour stage.

Test Plan:
- Reset held 5 cycles, released mid-line → rgb=0 and fb_rd=0 until the first vs rising edge. hs/vs/border_out track the inputs with 2-cycle delay throughout.
- After sync, line ay=24, ax=80..82 → fb_addr=0 on all three cycles; ax=83 → fb_addr=1; ax=559 → fb_addr=159. fb_rd is low at ax=79 and at ax=560.
- Lines 24/26/27 at ax=80 → fb_addr 0/0/160. Line 455 at ax=559 → fb_addr=23039; no fb_rd at line 456.
- Model RAM with fb_data = addr[1:0] → rgb at window pixel ax=83 equals 8BAC0F exactly 2 cycles after ax=83. Active pixel ax=10,ay=10 → BG_RGB; blanking → 0.
- vs_in forced high mid-frame (ay=200) → ay and row_base clear. Next window line starts at fb_addr=0 and no stale reads occur.
- Full 2-frame run against the sync generator with default timing → exactly 23040*9 fb_rd cycles per frame; output frame matches the reference image pixel-for-pixel.
